// File: rtl/prog_loader_pkg.sv
// Shared types and sizing for the byte-stream program loader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } loadState_t;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;
  localparam int CNT_W          = HDR_BYTES * BYTE_W;

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted stream bytes into little-endian byte lanes; pulses wordReady
// on the byte that completes a word.
module word_assembler #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          accept,
  input  logic [LANE_W-1:0]             byteIn,
  output logic [NUM_LANES*LANE_W-1:0]   word,
  output logic                          wordReady
);
  localparam int LW = $clog2(NUM_LANES);

  logic [LW-1:0]                        lane;
  logic [NUM_LANES-1:0][LANE_W-1:0]     lanes;

  assign word      = lanes;
  assign wordReady = accept && (lane == LW'(NUM_LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          lane <= '0;
    else if (clear)      lane <= '0;
    else if (wordReady)  lane <= '0;
    else if (accept)     lane <= lane + LW'(1);
  end

  // Lanes stay put between words, so the word is stable through the write strobe.
  for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                              lanes[g] <= '0;
      else if (clear)                          lanes[g] <= '0;
      else if (accept && lane == LW'(g))       lanes[g] <= byteIn;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Byte-stream program loader: writes an image through the pipeline's external
// memory port and holds the core until done. Option: PROG_LOADER_CHECKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        load_req,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);
  localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

  loadState_t       state, nextState;
  logic [CNT_W-1:0] wordCount;
  logic [CNT_W-1:0] hdrCount;
  logic             accept, restart, byteAccept, wordReady;

  assign accept     = rx_valid && rx_ready;
  assign restart    = load_req && (state == DONE || state == ERR);
  assign byteAccept = accept && (state == DATA);
  assign hdrCount   = {rx_data, wordCount[7:0]};

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam loadState_t LAST = CSUM;
  logic [7:0] xorSum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        xorSum <= '0;
    else if (restart)  xorSum <= '0;
    else if (accept && (state == LEN0 || state == LEN1 || state == DATA))
      xorSum <= xorSum ^ rx_data;
  end
`else
  localparam loadState_t LAST = DONE;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LEN0;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      LEN0:  if (accept) nextState = LEN1;
      LEN1:  if (accept) begin
               if (hdrCount == '0)                                  nextState = LAST;
               else if ({{(32-CNT_W){1'b0}}, hdrCount} > MAX_W)     nextState = ERR;
               else                                                 nextState = DATA;
             end
      DATA:  if (wordReady) nextState = WRITE;
      WRITE: nextState = (words_loaded + 16'd1 == wordCount) ? LAST : DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
      CSUM:  if (accept) nextState = (rx_data == xorSum) ? DONE : ERR;
`endif
      DONE,
      ERR:   if (load_req) nextState = LEN0;
      default: nextState = LEN0;
    endcase
  end

  // Flags are decoded from nextState so each output is a flop aligned with state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_ready     <= 1'b1;
      Ext_MemWrite <= 1'b0;
      Ext_DataAdr  <= BASE_ADDR;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      wordCount    <= '0;
    end else begin
      rx_ready     <= nextState inside {LEN0, LEN1, DATA, CSUM};
      Ext_MemWrite <= nextState == WRITE;
      core_hold    <= nextState != DONE;
      load_done    <= nextState == DONE;
      load_err     <= nextState == ERR;
      if (restart) begin
        words_loaded <= '0;
        wordCount    <= '0;
        Ext_DataAdr  <= BASE_ADDR;
      end else begin
        if (accept && state == LEN0) wordCount[7:0]  <= rx_data;
        if (accept && state == LEN1) wordCount[15:8] <= rx_data;
        if (wordReady)               Ext_DataAdr     <= BASE_ADDR + 32'({words_loaded, 2'b00});
        if (state == WRITE)          words_loaded    <= words_loaded + 16'd1;
      end
    end
  end

  word_assembler #(
    .NUM_LANES (BYTES_PER_WORD),
    .LANE_W    (BYTE_W)
  ) uAsm (
    .clk       (clk),
    .reset     (reset),
    .clear     (restart),
    .accept    (byteAccept),
    .byteIn    (rx_data),
    .word      (Ext_WriteData),
    .wordReady (wordReady)
  );

endmodule
